// File: rtl/lsu_controller.sv
// rtl/lsu_controller.sv - memory stage: one load/store at a time over AXI-lite, result to commit
module lsu_controller #(
  parameter int ADDR_W            = 32,
  parameter bit FAULT_ON_MISALIGN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_pre_i,
  output logic              ready_pre_o,
  input  logic              mem_ren_i,
  input  logic              mem_wen_i,
  input  logic [2:0]        mem_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [31:0]       alu_result_i,
  output logic              valid_post_o,
  input  logic              ready_post_i,
  output logic [31:0]       result_o,
  output logic              fault_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [31:0]       rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [31:0]       wdata_o,
  output logic [3:0]        wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B,
    S_DONE
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;

  logic        misaligned;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [31:0] rd_shift;
  logic [31:0] ld_ext;
  logic        aw_ok;
  logic        w_ok;

  // Alignment check on the incoming instruction (bytes are always aligned)
  always_comb begin
    misaligned = 1'b0;
    case (mem_op_i[1:0])
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = (addr_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Store lane steering: replicate the datum across the word, strobe the addressed lanes
  always_comb begin
    st_data = wdata_i;
    st_strb = 4'b1111;
    case (mem_op_i[1:0])
      2'b00: begin
        st_data = {4{wdata_i[7:0]}};
        st_strb = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        st_data = {2{wdata_i[15:0]}};
        st_strb = 4'b0011 << addr_i[1:0];
      end
      default: begin
        st_data = wdata_i;
        st_strb = 4'b1111;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down, then sign- or zero-extend
  always_comb begin
    rd_shift = rdata_i >> {lane_q, 3'b000};
    ld_ext   = rd_shift;
    case (op_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_ext = {24'h000000, rd_shift[7:0]};
      3'b101:  ld_ext = {16'h0000, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  // A write channel is finished once its valid has dropped or its ready is seen now
  assign aw_ok = !awvalid_o || awready_i;
  assign w_ok  = !wvalid_o  || wready_i;

  // Control FSM with all handshake and data outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      op_q         <= 3'b000;
      lane_q       <= 2'b00;
      ready_pre_o  <= 1'b1;
      valid_post_o <= 1'b0;
      result_o     <= 32'h0;
      fault_o      <= 1'b0;
      araddr_o     <= '0;
      arvalid_o    <= 1'b0;
      rready_o     <= 1'b0;
      awaddr_o     <= '0;
      awvalid_o    <= 1'b0;
      wdata_o      <= 32'h0;
      wstrb_o      <= 4'b0000;
      wvalid_o     <= 1'b0;
      bready_o     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_pre_i) begin
            op_q        <= mem_op_i;
            lane_q      <= addr_i[1:0];
            ready_pre_o <= 1'b0;
            result_o    <= 32'h0;
            fault_o     <= 1'b0;
            if (!mem_ren_i && !mem_wen_i) begin
              result_o     <= alu_result_i;
              valid_post_o <= 1'b1;
              state        <= S_DONE;
            end else if (mem_ren_i && mem_wen_i) begin
              fault_o      <= 1'b1;
              valid_post_o <= 1'b1;
              state        <= S_DONE;
            end else if (FAULT_ON_MISALIGN && misaligned) begin
              fault_o      <= 1'b1;
              valid_post_o <= 1'b1;
              state        <= S_DONE;
            end else if (mem_ren_i) begin
              araddr_o  <= addr_i;
              arvalid_o <= 1'b1;
              state     <= S_AR;
            end else begin
              awaddr_o  <= addr_i;
              wdata_o   <= st_data;
              wstrb_o   <= st_strb;
              awvalid_o <= 1'b1;
              wvalid_o  <= 1'b1;
              state     <= S_AW_W;
            end
          end
        end
        S_AR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= S_R;
          end
        end
        S_R: begin
          if (rvalid_i) begin
            rready_o     <= 1'b0;
            fault_o      <= (rresp_i != 2'b00);
            result_o     <= (rresp_i != 2'b00) ? 32'h0 : ld_ext;
            valid_post_o <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_AW_W: begin
          if (awready_i) awvalid_o <= 1'b0;
          if (wready_i)  wvalid_o  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready_o <= 1'b1;
            state    <= S_B;
          end
        end
        S_B: begin
          if (bvalid_i) begin
            bready_o     <= 1'b0;
            fault_o      <= (bresp_i != 2'b00);
            result_o     <= 32'h0;
            valid_post_o <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_post_i) begin
            valid_post_o <= 1'b0;
            ready_pre_o  <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: begin
          state        <= S_IDLE;
          ready_pre_o  <= 1'b1;
          valid_post_o <= 1'b0;
          arvalid_o    <= 1'b0;
          rready_o     <= 1'b0;
          awvalid_o    <= 1'b0;
          wvalid_o     <= 1'b0;
          bready_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// tb/tb_lsu_controller.sv - directed table-driven bench for lsu_controller
module tb_lsu_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_pre_i = 1'b0;
  logic        ready_pre_o;
  logic        mem_ren_i = 1'b0;
  logic        mem_wen_i = 1'b0;
  logic [2:0]  mem_op_i = 3'b000;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] alu_result_i = 32'h0;
  logic        valid_post_o;
  logic        ready_post_i = 1'b0;
  logic [31:0] result_o;
  logic        fault_o;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [31:0] rdata_i = 32'h0;
  logic [1:0]  rresp_i = 2'b00;
  logic        rvalid_i = 1'b0;
  logic        rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o;
  logic        awready_i = 1'b0;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o;
  logic        wready_i = 1'b0;
  logic [1:0]  bresp_i = 2'b00;
  logic        bvalid_i = 1'b0;
  logic        bready_o;

  int checks = 0;
  int errors = 0;

  lsu_controller #(.ADDR_W(32), .FAULT_ON_MISALIGN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
    .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i), .mem_op_i(mem_op_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .alu_result_i(alu_result_i),
    .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
    .result_o(result_o), .fault_o(fault_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        ren;
    logic        wen;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [1:0]  bus;        // 0 none, 1 read, 2 write
    logic [31:0] exp_result;
    logic        exp_fault;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_pre_i = 1'b0;
    mem_ren_i   = 1'b0;
    mem_wen_i   = 1'b0;
  endtask

  task automatic present(input logic ren, input logic wen, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] alu);
    @(negedge clock);
    valid_pre_i  = 1'b1;
    mem_ren_i    = ren;
    mem_wen_i    = wen;
    mem_op_i     = op;
    addr_i       = addr;
    wdata_i      = wd;
    alu_result_i = alu;
    @(posedge clock);
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic finish_commit(input string name);
    ready_post_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ready_post_i = 1'b0;
    check({name, ".post_cleared"}, {31'b0, valid_post_o}, 32'd0);
    check({name, ".ready_pre_back"}, {31'b0, ready_pre_o}, 32'd1);
  endtask

  // Zero-wait slave sequence; checks happen one cycle after each edge
  task automatic run_vec(input vec_t v);
    present(v.ren, v.wen, v.op, v.addr, v.wdata, v.alu);
    check({v.name, ".ready_pre_busy"}, {31'b0, ready_pre_o}, 32'd0);
    if (v.bus == 2'd1) begin
      check({v.name, ".arvalid"}, {31'b0, arvalid_o}, 32'd1);
      check({v.name, ".araddr"}, araddr_o, v.addr);
      check({v.name, ".early_post"}, {31'b0, valid_post_o}, 32'd0);
      arready_i = 1'b1;
      @(posedge clock);
      @(negedge clock);
      arready_i = 1'b0;
      check({v.name, ".rready"}, {31'b0, rready_o}, 32'd1);
      rdata_i  = v.rdata;
      rresp_i  = v.resp;
      rvalid_i = 1'b1;
      @(posedge clock);
      @(negedge clock);
      rvalid_i = 1'b0;
    end else if (v.bus == 2'd2) begin
      check({v.name, ".awvalid"}, {31'b0, awvalid_o}, 32'd1);
      check({v.name, ".wvalid"}, {31'b0, wvalid_o}, 32'd1);
      check({v.name, ".awaddr"}, awaddr_o, v.addr);
      check({v.name, ".wdata"}, wdata_o, v.exp_wdata);
      check({v.name, ".wstrb"}, {28'b0, wstrb_o}, {28'b0, v.exp_wstrb});
      awready_i = 1'b1;
      wready_i  = 1'b1;
      @(posedge clock);
      @(negedge clock);
      awready_i = 1'b0;
      wready_i  = 1'b0;
      check({v.name, ".bready"}, {31'b0, bready_o}, 32'd1);
      bresp_i  = v.resp;
      bvalid_i = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bvalid_i = 1'b0;
    end else begin
      check({v.name, ".no_ar"}, {31'b0, arvalid_o}, 32'd0);
      check({v.name, ".no_aw"}, {31'b0, awvalid_o}, 32'd0);
    end
    check({v.name, ".valid_post"}, {31'b0, valid_post_o}, 32'd1);
    check({v.name, ".result"}, result_o, v.exp_result);
    check({v.name, ".fault"}, {31'b0, fault_o}, {31'b0, v.exp_fault});
    finish_commit(v.name);
  endtask

  initial begin
    //            name     ren   wen   op      addr          wdata         alu           rdata         resp   bus   result        flt   wdata_o       wstrb
    vecs[0]  = '{"alu",    1'b0, 1'b0, 3'b000, 32'h00000000, 32'h0,        32'h00001234, 32'h0,        2'b00, 2'd0, 32'h00001234, 1'b0, 32'h0,        4'b0000};
    vecs[1]  = '{"lb",     1'b1, 1'b0, 3'b000, 32'h80000003, 32'h0,        32'h0,        32'h80FFFFFF, 2'b00, 2'd1, 32'hFFFFFF80, 1'b0, 32'h0,        4'b0000};
    vecs[2]  = '{"lbu",    1'b1, 1'b0, 3'b100, 32'h80000003, 32'h0,        32'h0,        32'h80FFFFFF, 2'b00, 2'd1, 32'h00000080, 1'b0, 32'h0,        4'b0000};
    vecs[3]  = '{"lh",     1'b1, 1'b0, 3'b001, 32'h80000002, 32'h0,        32'h0,        32'h80010000, 2'b00, 2'd1, 32'hFFFF8001, 1'b0, 32'h0,        4'b0000};
    vecs[4]  = '{"lhu",    1'b1, 1'b0, 3'b101, 32'h80000002, 32'h0,        32'h0,        32'h80010000, 2'b00, 2'd1, 32'h00008001, 1'b0, 32'h0,        4'b0000};
    vecs[5]  = '{"lw",     1'b1, 1'b0, 3'b010, 32'h80000004, 32'h0,        32'h0,        32'hDEADBEEF, 2'b00, 2'd1, 32'hDEADBEEF, 1'b0, 32'h0,        4'b0000};
    vecs[6]  = '{"lb1",    1'b1, 1'b0, 3'b000, 32'h80000001, 32'h0,        32'h0,        32'h00007F00, 2'b00, 2'd1, 32'h0000007F, 1'b0, 32'h0,        4'b0000};
    vecs[7]  = '{"sb",     1'b0, 1'b1, 3'b000, 32'h80000001, 32'h123456AB, 32'h0,        32'h0,        2'b00, 2'd2, 32'h00000000, 1'b0, 32'hABABABAB, 4'b0010};
    vecs[8]  = '{"sw",     1'b0, 1'b1, 3'b010, 32'h80000010, 32'hCAFEF00D, 32'h0,        32'h0,        2'b00, 2'd2, 32'h00000000, 1'b0, 32'hCAFEF00D, 4'b1111};
    vecs[9]  = '{"lw_mis", 1'b1, 1'b0, 3'b010, 32'h80000001, 32'h0,        32'h55555555, 32'h0,        2'b00, 2'd0, 32'h00000000, 1'b1, 32'h0,        4'b0000};
    vecs[10] = '{"sh_mis", 1'b0, 1'b1, 3'b001, 32'h80000003, 32'h0000ABCD, 32'h55555555, 32'h0,        2'b00, 2'd0, 32'h00000000, 1'b1, 32'h0,        4'b0000};
    vecs[11] = '{"rw",     1'b1, 1'b1, 3'b010, 32'h80000000, 32'h0,        32'h55555555, 32'h0,        2'b00, 2'd0, 32'h00000000, 1'b1, 32'h0,        4'b0000};

    // Reset state
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst.ready_pre", {31'b0, ready_pre_o}, 32'd1);
    check("rst.valid_post", {31'b0, valid_post_o}, 32'd0);
    check("rst.valids", {27'b0, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 32'd0);
    check("rst.result", result_o, 32'd0);
    check("rst.fault", {31'b0, fault_o}, 32'd0);
    check("rst.wstrb", {28'b0, wstrb_o}, 32'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // LB with arready delayed two cycles: arvalid and araddr must hold
    present(1'b1, 1'b0, 3'b000, 32'h80000003, 32'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      check("lbd.arvalid_hold", {31'b0, arvalid_o}, 32'd1);
      check("lbd.araddr_hold", araddr_o, 32'h80000003);
      @(negedge clock);
    end
    arready_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    arready_i = 1'b0;
    check("lbd.arvalid_drop", {31'b0, arvalid_o}, 32'd0);
    rdata_i  = 32'h80FFFFFF;
    rresp_i  = 2'b00;
    rvalid_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rvalid_i = 1'b0;
    check("lbd.result", result_o, 32'hFFFFFF80);
    finish_commit("lbd");

    // SH with awready one cycle after accept and wready three cycles after
    present(1'b0, 1'b1, 3'b001, 32'h80000002, 32'h0000ABCD, 32'h0);
    check("sh.wdata", wdata_o, 32'hABCDABCD);
    check("sh.wstrb", {28'b0, wstrb_o}, 32'h0000000C);
    awready_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    awready_i = 1'b0;
    check("sh.aw_drop", {31'b0, awvalid_o}, 32'd0);
    check("sh.w_hold1", {31'b0, wvalid_o}, 32'd1);
    check("sh.no_b1", {31'b0, bready_o}, 32'd0);
    @(negedge clock);
    check("sh.w_hold2", {31'b0, wvalid_o}, 32'd1);
    check("sh.no_b2", {31'b0, bready_o}, 32'd0);
    wready_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    wready_i = 1'b0;
    check("sh.w_drop", {31'b0, wvalid_o}, 32'd0);
    check("sh.bready", {31'b0, bready_o}, 32'd1);
    bresp_i  = 2'b00;
    bvalid_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bvalid_i = 1'b0;
    check("sh.post", {31'b0, valid_post_o}, 32'd1);
    check("sh.fault", {31'b0, fault_o}, 32'd0);
    finish_commit("sh");

    // LW with SLVERR, then commit stalls for three cycles
    present(1'b1, 1'b0, 3'b010, 32'h80000008, 32'h0, 32'h0);
    arready_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    arready_i = 1'b0;
    rdata_i  = 32'h12345678;
    rresp_i  = 2'b10;
    rvalid_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rvalid_i = 1'b0;
    rresp_i  = 2'b00;
    for (int k = 0; k < 3; k++) begin
      check("err.valid_post", {31'b0, valid_post_o}, 32'd1);
      check("err.fault", {31'b0, fault_o}, 32'd1);
      check("err.result", result_o, 32'd0);
      check("err.ready_pre", {31'b0, ready_pre_o}, 32'd0);
      @(negedge clock);
    end
    finish_commit("err");

    // Reset while waiting for R
    present(1'b1, 1'b0, 3'b010, 32'h80000000, 32'h0, 32'h0);
    arready_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    arready_i = 1'b0;
    check("mid.rready", {31'b0, rready_o}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("mid.rready_low", {31'b0, rready_o}, 32'd0);
    check("mid.valid_post", {31'b0, valid_post_o}, 32'd0);
    check("mid.ready_pre", {31'b0, ready_pre_o}, 32'd1);
    check("mid.arvalid", {31'b0, arvalid_o}, 32'd0);

    // Accept still works after the mid-transaction reset
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
